// File: rtl/apb_gpio_regs.sv
// APB GPIO register block. Sits after the APB slave handshake FSM, which
// supplies PREADY. It commits register reads and writes on completed transfers,
// holds the output, direction and interrupt registers, synchronises the input
// pins, detects edges on them and drives a level interrupt request.
//
// Handshake: a transfer completes in any cycle where PSEL & PENABLE & PREADY
// are all high. Writes take effect on the PCLK edge that ends that cycle.
// Setup cycles (PENABLE=0) and access cycles with PREADY=0 change no state.
// PRDATA is valid throughout the access phase of a read. PSLVERR is valid only
// in the completing cycle.
module apb_gpio_regs #(
  parameter int GPIO_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  input  logic              PREADY,
  output logic [31:0]       PRDATA,
  output logic              PSLVERR,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  // Word offsets taken from PADDR[4:2]
  localparam logic [2:0] OFF_DATA_OUT   = 3'd0;
  localparam logic [2:0] OFF_DIR        = 3'd1;
  localparam logic [2:0] OFF_DATA_IN    = 3'd2;
  localparam logic [2:0] OFF_INT_EN     = 3'd3;
  localparam logic [2:0] OFF_INT_POL    = 3'd4;
  localparam logic [2:0] OFF_INT_STATUS = 3'd5;

  // Architectural registers
  logic [GPIO_W-1:0] data_out_q;
  logic [GPIO_W-1:0] dir_q;
  logic [GPIO_W-1:0] int_en_q;
  logic [GPIO_W-1:0] int_pol_q;
  logic [GPIO_W-1:0] int_status_q;
  logic              irq_q;

  // Input path flops
  logic [GPIO_W-1:0] sync1_q;
  logic [GPIO_W-1:0] sync2_q;
  logic [GPIO_W-1:0] prev_q;

  // Decode
  logic [2:0]        offset;
  logic [ADDR_W-1:0] addr_hi;
  logic              addr_mapped;
  logic              xfer;
  logic              rd_access;
  logic              wr_xfer;
  logic [GPIO_W-1:0] wdata;
  logic [GPIO_W-1:0] status_clr;

  // Edge detection
  logic [GPIO_W-1:0] rise;
  logic [GPIO_W-1:0] fall;
  logic [GPIO_W-1:0] edge_det;

  // Read mux
  logic [GPIO_W-1:0] rd_word;

  // Byte-lane bits and write data above GPIO_W are deliberately not decoded
  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  assign offset  = PADDR[4:2];
  assign addr_hi = PADDR >> 5;

  // Offsets 6 and 7, and anything with high address bits set, are holes
  assign addr_mapped = (addr_hi == '0) && (offset <= OFF_INT_STATUS);

  assign xfer      = PSEL & PENABLE & PREADY;
  assign rd_access = PSEL & PENABLE & ~PWRITE;
  assign wr_xfer   = xfer & PWRITE & addr_mapped;
  assign wdata     = PWDATA[GPIO_W-1:0];

  // Write-one-to-clear mask for INT_STATUS, only during a committing write
  assign status_clr = (wr_xfer && (offset == OFF_INT_STATUS)) ? wdata : '0;

  // Edges are seen on the synchronised value against its one-cycle delay, so
  // a polarity change alone can never manufacture an edge.
  assign rise     = sync2_q & ~prev_q;
  assign fall     = ~sync2_q & prev_q;
  assign edge_det = (int_pol_q & rise) | (~int_pol_q & fall);

  // Select the register addressed by the current access
  always_comb begin
    rd_word = '0;
    case (offset)
      OFF_DATA_OUT:   rd_word = data_out_q;
      OFF_DIR:        rd_word = dir_q;
      OFF_DATA_IN:    rd_word = sync2_q;
      OFF_INT_EN:     rd_word = int_en_q;
      OFF_INT_POL:    rd_word = int_pol_q;
      OFF_INT_STATUS: rd_word = int_status_q;
      default:        rd_word = '0;
    endcase
  end

  // Drive read data during a read access phase, zero-extended; holes read 0.
  // Reset forces the bus outputs low even if the master keeps driving.
  always_comb begin
    PRDATA = '0;
    if (PRESETn && rd_access && addr_mapped) begin
      PRDATA[GPIO_W-1:0] = rd_word;
    end
  end

  // Error response only in the completing cycle of an access to a hole
  assign PSLVERR = PRESETn & xfer & ~addr_mapped;

  // Control registers written by committed APB writes
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      data_out_q <= '0;
      dir_q      <= '0;
      int_en_q   <= '0;
      int_pol_q  <= '0;
    end else if (wr_xfer) begin
      case (offset)
        OFF_DATA_OUT: data_out_q <= wdata;
        OFF_DIR:      dir_q      <= wdata;
        OFF_INT_EN:   int_en_q   <= wdata;
        OFF_INT_POL:  int_pol_q  <= wdata;
        default:      ;
      endcase
    end
  end

  // Two-flop synchroniser plus the previous-value flop for edge detection
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Sticky status: a new edge outranks a clear landing in the same cycle
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      int_status_q <= '0;
    end else begin
      int_status_q <= (int_status_q & ~status_clr) | edge_det;
    end
  end

  // Registered level interrupt from enabled status bits
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(int_status_q & int_en_q);
    end
  end

  assign gpio_out = data_out_q & dir_q;
  assign gpio_oe  = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_apb_gpio_regs.sv
// Bench for apb_gpio_regs: directed APB transfers with a read scoreboard,
// cycle-exact checks on the input path and interrupt timing.
module tb_apb_gpio_regs;

  logic        PCLK;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  // {expected PSLVERR, expected PRDATA} per read
  logic [32:0] exp_q[$];

  logic [7:0] cur_out;

  apb_gpio_regs #(.GPIO_W(8), .ADDR_W(8)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  // Clock and watchdog
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic bus_idle();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PREADY = 1'b0;
    PADDR = '0; PWDATA = '0;
  endtask

  // Zero-wait write; returns on the negedge after the commit edge
  task automatic apb_write(input logic [7:0] addr, input logic [31:0] data, input logic exp_err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PREADY = 1'b0;
    #1 check_eq("wr_setup_slverr", {31'd0, PSLVERR}, 32'd0);
    @(negedge PCLK);
    PENABLE = 1'b1; PREADY = 1'b1;
    #1 check_eq("wr_slverr", {31'd0, PSLVERR}, {31'd0, exp_err});
    @(negedge PCLK);
    bus_idle();
  endtask

  // Read with optional wait states; expectation is queued up front and
  // popped when the transfer completes
  task automatic apb_read(input logic [7:0] addr, input logic [31:0] exp_data,
                          input logic exp_err, input int waits);
    logic [32:0] e;
    exp_q.push_back({exp_err, exp_data});
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr; PREADY = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    for (int i = 0; i < waits; i++) begin
      #1 check_eq("rd_wait_slverr", {31'd0, PSLVERR}, 32'd0);
      @(negedge PCLK);
    end
    PREADY = 1'b1;
    #1;
    e = exp_q.pop_front();
    check_eq($sformatf("rd_data@%02h", addr), PRDATA, e[31:0]);
    check_eq($sformatf("rd_slverr@%02h", addr), {31'd0, PSLVERR}, {31'd0, e[32]});
    @(negedge PCLK);
    bus_idle();
    #1 check_eq("rd_after_slverr", {31'd0, PSLVERR}, 32'd0);
  endtask

  initial begin
    bus_idle();
    gpio_in = 8'hFF;
    PRESETn = 1'b0;
    cur_out = 8'h00;

    // Reset: outputs low even with pins high and a hole being read
    repeat (2) @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b1; PREADY = 1'b1; PADDR = 8'h18;
    #1;
    check_eq("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
    check_eq("rst_gpio_oe",  {24'd0, gpio_oe},  32'd0);
    check_eq("rst_irq",      {31'd0, irq},      32'd0);
    check_eq("rst_prdata",   PRDATA,            32'd0);
    check_eq("rst_pslverr",  {31'd0, PSLVERR},  32'd0);
    @(negedge PCLK);
    bus_idle();
    PRESETn = 1'b1;

    apb_read(8'h00, 32'h0, 1'b0, 0);
    apb_read(8'h04, 32'h0, 1'b0, 0);
    apb_read(8'h0C, 32'h0, 1'b0, 0);
    apb_read(8'h10, 32'h0, 1'b0, 0);
    apb_read(8'h14, 32'h0, 1'b0, 0);
    apb_read(8'h08, 32'hFF, 1'b0, 0);

    // Re-reset with pins low so no falling edges are left behind
    gpio_in = 8'h00;
    @(negedge PCLK);
    PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (3) @(negedge PCLK);

    // Output path
    apb_write(8'h04, 32'hF0, 1'b0);
    apb_write(8'h00, 32'hAA, 1'b0);
    cur_out = 8'hAA;
    check_eq("out_oe",   {24'd0, gpio_oe},  32'hF0);
    check_eq("out_data", {24'd0, gpio_out}, 32'hA0);
    apb_read(8'h00, 32'hAA, 1'b0, 0);
    apb_read(8'h04, 32'hF0, 1'b0, 0);
    apb_read(8'h05, 32'hF0, 1'b0, 0);

    // Rising edge on pin 0: watch DATA_IN and irq cycle by cycle
    apb_write(8'h10, 32'h01, 1'b0);
    apb_write(8'h0C, 32'h01, 1'b0);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'h08; PREADY = 1'b0;
    gpio_in = 8'h01;
    @(posedge PCLK); #1 check_eq("rise_din_e1", PRDATA, 32'h00);
    @(posedge PCLK); #1 check_eq("rise_din_e2", PRDATA, 32'h01);
    @(posedge PCLK); #1 check_eq("rise_irq_e3", {31'd0, irq}, 32'd0);
    @(posedge PCLK); #1 check_eq("rise_irq_e4", {31'd0, irq}, 32'd1);
    @(negedge PCLK);
    bus_idle();
    apb_read(8'h14, 32'h01, 1'b0, 0);
    apb_write(8'h14, 32'h01, 1'b0);
    check_eq("w1c_irq_hold", {31'd0, irq}, 32'd1);
    @(posedge PCLK); #1 check_eq("w1c_irq_fall", {31'd0, irq}, 32'd0);
    apb_read(8'h14, 32'h00, 1'b0, 0);

    // Falling edge on pin 3 with interrupt masked, then unmask
    apb_write(8'h10, 32'h00, 1'b0);
    apb_write(8'h0C, 32'h00, 1'b0);
    gpio_in = 8'h09;
    repeat (5) @(negedge PCLK);
    gpio_in = 8'h01;
    repeat (5) @(negedge PCLK);
    apb_read(8'h14, 32'h08, 1'b0, 0);
    check_eq("mask_irq_low", {31'd0, irq}, 32'd0);
    apb_write(8'h0C, 32'h08, 1'b0);
    check_eq("unmask_irq_e0", {31'd0, irq}, 32'd0);
    @(posedge PCLK); #1 check_eq("unmask_irq_e1", {31'd0, irq}, 32'd1);

    // Set/clear collision on pin 0
    apb_write(8'h14, 32'h08, 1'b0);
    apb_write(8'h10, 32'h01, 1'b0);
    apb_write(8'h0C, 32'h01, 1'b0);
    gpio_in = 8'h00;
    repeat (5) @(negedge PCLK);
    apb_read(8'h14, 32'h00, 1'b0, 0);
    gpio_in = 8'h01;
    repeat (5) @(negedge PCLK);
    gpio_in = 8'h00;
    repeat (5) @(negedge PCLK);
    check_eq("coll_pre_irq", {31'd0, irq}, 32'd1);
    // Pin change here lands its status set on the same edge as the W1C commit
    gpio_in = 8'h01;
    apb_write(8'h14, 32'h01, 1'b0);
    repeat (2) @(posedge PCLK);
    #1 check_eq("coll_irq", {31'd0, irq}, 32'd1);
    apb_read(8'h14, 32'h01, 1'b0, 0);

    // Random output data
    for (int i = 0; i < 4; i++) begin
      cur_out = 8'($urandom_range(0, 255));
      apb_write(8'h00, {24'd0, cur_out}, 1'b0);
      check_eq("rand_gpio_out", {24'd0, gpio_out}, {24'd0, cur_out & 8'hF0});
      apb_read(8'h00, {24'd0, cur_out}, 1'b0, 0);
    end

    // Holes and read-only register
    apb_read(8'h18, 32'h0, 1'b1, 2);
    apb_read(8'h1C, 32'h0, 1'b1, 0);
    apb_read(8'h40, 32'h0, 1'b1, 0);
    apb_write(8'h1C, 32'hFFFF_FFFF, 1'b1);
    apb_write(8'h20, 32'hFFFF_FFFF, 1'b1);
    apb_write(8'h08, 32'hFF, 1'b0);
    apb_read(8'h08, 32'h01, 1'b0, 0);
    apb_read(8'h00, {24'd0, cur_out}, 1'b0, 0);
    apb_read(8'h04, 32'hF0, 1'b0, 0);

    // Write with three wait states
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h55; PREADY = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK);
      #1 check_eq("wait_hold_out", {24'd0, gpio_out}, {24'd0, cur_out & 8'hF0});
    end
    @(negedge PCLK);
    PREADY = 1'b1;
    @(posedge PCLK);
    #1 check_eq("wait_commit_out", {24'd0, gpio_out}, 32'h50);
    cur_out = 8'h55;
    @(negedge PCLK);
    bus_idle();
    apb_read(8'h00, 32'h55, 1'b0, 0);

    // Reset in the middle of an access phase
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h33; PREADY = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #2 PRESETn = 1'b0;
    #1;
    check_eq("midrst_gpio_out", {24'd0, gpio_out}, 32'd0);
    check_eq("midrst_gpio_oe",  {24'd0, gpio_oe},  32'd0);
    check_eq("midrst_irq",      {31'd0, irq},      32'd0);
    @(negedge PCLK);
    bus_idle();
    @(negedge PCLK);
    PRESETn = 1'b1;
    apb_read(8'h00, 32'h0, 1'b0, 0);
    apb_read(8'h04, 32'h0, 1'b0, 0);
    apb_read(8'h14, 32'h0, 1'b0, 0);

    check_eq("exp_q_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
